// File: rtl/ladner_adder_pipe.sv
// Pipelined Ladner-Fischer prefix adder: one prefix level per register stage, global stall.
// Optional signed-overflow output enabled by defining LADNER_OVF_EN.
module ladner_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int LOG2W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef LADNER_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (LOG2W != $clog2(WIDTH) || WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_param_check
        $error("ladner_adder_pipe: WIDTH must be a power of two in 4..64 and LOG2W == clog2(WIDTH)");
    end

    logic             adv;
    logic [LOG2W:0]   vld_q;
    logic [LOG2W:0]   cin_q;
    logic [WIDTH-1:0] p_q [0:LOG2W];
    logic [WIDTH-1:0] g_q [0:LOG2W];
    logic [WIDTH-1:0] h_q [0:LOG2W];
    logic [WIDTH-1:0] p_d [0:LOG2W];
    logic [WIDTH-1:0] g_d [0:LOG2W];

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

    // Entry 0 is the operand pre-processing; entry k+1 is prefix level k applied to registered entry k.
    always_comb begin
        int j;
        j      = 0;
        p_d[0] = a ^ b;
        g_d[0] = a & b;
        g_d[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        for (int k = 0; k < LOG2W; k++) begin
            p_d[k+1] = p_q[k];
            g_d[k+1] = g_q[k];
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> k) & 1) == 1) begin
                    j = ((i >> (k + 1)) << (k + 1)) + (1 << k) - 1;
                    g_d[k+1][i] = g_q[k][i] | (p_q[k][i] & g_q[k][j]);
                    p_d[k+1][i] = p_q[k][i] & p_q[k][j];
                end
            end
        end
    end

    always_comb begin
        sum_d  = h_q[LOG2W] ^ {g_q[LOG2W][WIDTH-2:0], cin_q[LOG2W]};
        cout_d = g_q[LOG2W][WIDTH-1];
    end

`ifdef LADNER_OVF_EN
    logic [LOG2W:0] sa_q, sb_q;
    logic           ovf_q, ovf_d;

    assign ovf_d = (sa_q[LOG2W] == sb_q[LOG2W]) && (sum_d[WIDTH-1] != sa_q[LOG2W]);
    assign ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (adv) begin
            sa_q <= {sa_q[LOG2W-1:0], a[WIDTH-1]};
            sb_q <= {sb_q[LOG2W-1:0], b[WIDTH-1]};
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef LADNER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else if (adv) begin
            vld_q       <= {vld_q[LOG2W-1:0], in_valid};
            out_valid_q <= vld_q[LOG2W];
            // Outputs only change on a real result, so bubbles leave the last result visible.
            if (vld_q[LOG2W]) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
`ifdef LADNER_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            cin_q  <= {cin_q[LOG2W-1:0], cin};
            h_q[0] <= p_d[0];
            for (int k = 0; k <= LOG2W; k++) begin
                p_q[k] <= p_d[k];
                g_q[k] <= g_d[k];
            end
            for (int k = 0; k < LOG2W; k++) begin
                h_q[k+1] <= h_q[k];
            end
        end
    end

endmodule
